// File: rtl/cola_pkg.sv
// Command codes shared by the button queue and the snake movement state machine.
// Holds the code width, code constants, button indices and the fixed priority encoder.
package cola_pkg;

  localparam int CMD_W = 3;
  typedef logic [CMD_W-1:0] cmd_t;

  localparam cmd_t CMD_NADA      = 3'd0;
  localparam cmd_t CMD_ARRIBA    = 3'd1;
  localparam cmd_t CMD_ABAJO     = 3'd2;
  localparam cmd_t CMD_IZQUIERDA = 3'd3;
  localparam cmd_t CMD_DERECHA   = 3'd4;
  localparam cmd_t CMD_PAUSA     = 3'd5;

  // Bit positions of each button inside the event vector.
  localparam int NUM_BOTONES   = 5;
  localparam int BTN_ARRIBA    = 0;
  localparam int BTN_ABAJO     = 1;
  localparam int BTN_IZQUIERDA = 2;
  localparam int BTN_DERECHA   = 3;
  localparam int BTN_PAUSA     = 4;

  // Fixed priority: pause first, then up, down, left, right. Losers are discarded.
  function automatic cmd_t codificar(input logic [NUM_BOTONES-1:0] ev);
    cmd_t c;
    if (ev[BTN_PAUSA]) begin
      c = CMD_PAUSA;
    end else if (ev[BTN_ARRIBA]) begin
      c = CMD_ARRIBA;
    end else if (ev[BTN_ABAJO]) begin
      c = CMD_ABAJO;
    end else if (ev[BTN_IZQUIERDA]) begin
      c = CMD_IZQUIERDA;
    end else if (ev[BTN_DERECHA]) begin
      c = CMD_DERECHA;
    end else begin
      c = CMD_NADA;
    end
    return c;
  endfunction

endpackage

// File: rtl/cola_comandos_antirrebote.sv
// antirrebote: single-button debouncer. A raw level must differ from the accepted level for
// DEB_CYCLES consecutive cycles before it is accepted; an accepted rising level raises a
// one-cycle flanco pulse in the same cycle the new level becomes visible.
module antirrebote #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic entrada,
  output logic nivel,
  output logic flanco
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_UNO = CW'(1);

  logic [CW-1:0] cnt_r;
  logic          nivel_r;
  logic          flanco_r;

  // Count consecutive disagreeing cycles; flip the level and clear when the run completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= '0;
      nivel_r  <= 1'b0;
      flanco_r <= 1'b0;
    end else if (entrada != nivel_r) begin
      if (cnt_r == CNT_MAX) begin
        cnt_r    <= '0;
        nivel_r  <= entrada;
        flanco_r <= entrada;
      end else begin
        cnt_r    <= cnt_r + CNT_UNO;
        flanco_r <= 1'b0;
      end
    end else begin
      cnt_r    <= '0;
      flanco_r <= 1'b0;
    end
  end

  assign nivel  = nivel_r;
  assign flanco = flanco_r;

endmodule

// File: rtl/cola_comandos.sv
// cola_comandos: debounces the five buttons, encodes one command per cycle by fixed priority and
// queues the codes in a DEPTH-entry FIFO whose head is shown on siguiente.
// Optional build macro: COLA_DESCARTE_REPETIDO_EN suppresses a code equal to the last one pushed.
module cola_comandos
  import cola_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arriba,
  input  logic       abajo,
  input  logic       izquierda,
  input  logic       derecha,
  input  logic       pausa,
  input  logic       consumir,
  output logic [2:0] siguiente,
  output logic       vacia,
  output logic       llena,
  output logic [7:0] descartes
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_UNO = (AW + 1)'(1);

  logic [NUM_BOTONES-1:0] crudo_s;
  logic [NUM_BOTONES-1:0] nivel_s;
  logic [NUM_BOTONES-1:0] flanco_s;
  logic [NUM_BOTONES-1:0] evento_s;

  cmd_t        mem_r [DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic [7:0]  descartes_r;

  cmd_t codigo_s;
  logic repetido_s;
  logic vacia_s;
  logic llena_s;
  logic pop_s;
  logic push_s;
  logic drop_s;

  assign crudo_s[BTN_ARRIBA]    = arriba;
  assign crudo_s[BTN_ABAJO]     = abajo;
  assign crudo_s[BTN_IZQUIERDA] = izquierda;
  assign crudo_s[BTN_DERECHA]   = derecha;
  assign crudo_s[BTN_PAUSA]     = pausa;

  for (genvar i = 0; i < NUM_BOTONES; i++) begin : g_antirrebote
    antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_antirrebote (
      .clk     (clk),
      .rst     (rst),
      .entrada (crudo_s[i]),
      .nivel   (nivel_s[i]),
      .flanco  (flanco_s[i])
    );
  end

  // An event is a rising edge that has been accepted as the new debounced level.
  assign evento_s = flanco_s & nivel_s;
  assign codigo_s = codificar(evento_s);

`ifdef COLA_DESCARTE_REPETIDO_EN
  cmd_t ultimo_r;

  // Remember the last code actually written so an identical follow-up can be suppressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      ultimo_r <= CMD_NADA;
    end else if (push_s) begin
      ultimo_r <= codigo_s;
    end else begin
      ultimo_r <= ultimo_r;
    end
  end

  assign repetido_s = (codigo_s == ultimo_r);
`else
  assign repetido_s = 1'b0;
`endif

  assign vacia_s = (wr_ptr_r == rd_ptr_r);
  assign llena_s = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);

  // Push/pop/drop decisions; a pop on a full FIFO frees the slot for a same-cycle push.
  always_comb begin
    pop_s  = 1'b0;
    push_s = 1'b0;
    drop_s = 1'b0;
    pop_s = consumir && !vacia_s;
    if ((codigo_s != CMD_NADA) && !repetido_s) begin
      if (!llena_s || pop_s) begin
        push_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      push_s = 1'b0;
      drop_s = 1'b0;
    end
  end

  // Storage is not cleared on reset; the empty flag masks stale entries on siguiente.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= codigo_s;
    end
  end

  // Pointer update; the extra wrap bit distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_UNO;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_UNO;
      end
    end
  end

  // Saturating count of codes lost because the FIFO was full.
  always_ff @(posedge clk) begin
    if (rst) begin
      descartes_r <= 8'd0;
    end else if (drop_s && (descartes_r != 8'hFF)) begin
      descartes_r <= descartes_r + 8'd1;
    end else begin
      descartes_r <= descartes_r;
    end
  end

  assign siguiente = vacia_s ? CMD_NADA : mem_r[rd_ptr_r[AW-1:0]];
  assign vacia     = vacia_s;
  assign llena     = llena_s;
  assign descartes = descartes_r;

endmodule

// File: tb/tb_cola_comandos.sv
// Self-checking bench for cola_comandos (DEB_CYCLES=8, DEPTH=4): directed scenarios plus
// random button/consume traffic, all checked every cycle against a queue-based reference model.
module tb_cola_comandos;

  localparam int DEB   = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn;  // 0 up, 1 down, 2 left, 3 right, 4 pause
  logic       consumir;
  logic [2:0] siguiente;
  logic       vacia;
  logic       llena;
  logic [7:0] descartes;

  cola_comandos #(.DEPTH(DEPTH), .DEB_CYCLES(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .arriba    (btn[0]),
    .abajo     (btn[1]),
    .izquierda (btn[2]),
    .derecha   (btn[3]),
    .pausa     (btn[4]),
    .consumir  (consumir),
    .siguiente (siguiente),
    .vacia     (vacia),
    .llena     (llena),
    .descartes (descartes)
  );

  always #5 clk = ~clk;

  int n_comp = 0;
  int n_fail = 0;

  // Reference model state
  int m_lvl [5];
  int m_run [5];
  bit m_ev  [5];
  int q [$];
  int m_desc;
  int m_last;

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_comp++;
    if (obs !== esp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, esp, $time);
    end
  endtask

  // One clock edge of the reference model, using the inputs present at that edge.
  task automatic modelo_paso();
    int  code;
    bit  pop;
    bit  full;
    bit  rep;
    if (rst) begin
      for (int b = 0; b < 5; b++) begin
        m_lvl[b] = 0; m_run[b] = 0; m_ev[b] = 1'b0;
      end
      q.delete();
      m_desc = 0;
      m_last = 0;
    end else begin
      code = 0;
      if (m_ev[4]) code = 5;
      else for (int b = 0; b < 4; b++) if (m_ev[b] && code == 0) code = b + 1;
      full = (q.size() == DEPTH);
      pop  = consumir && (q.size() > 0);
      if (pop) void'(q.pop_front());
      rep = 1'b0;
`ifdef COLA_DESCARTE_REPETIDO_EN
      rep = (code == m_last);
`endif
      if (code != 0 && !rep) begin
        if (!full || pop) begin
          q.push_back(code);
          m_last = code;
        end else if (m_desc < 255) begin
          m_desc++;
        end
      end
      for (int b = 0; b < 5; b++) begin
        m_ev[b] = 1'b0;
        if (int'(btn[b]) != m_lvl[b]) begin
          if (m_run[b] == DEB - 1) begin
            m_lvl[b] = int'(btn[b]);
            m_run[b] = 0;
            m_ev[b]  = btn[b];
          end else begin
            m_run[b]++;
          end
        end else begin
          m_run[b] = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelo_paso();
    #1;
    comprobar("siguiente", siguiente, (q.size() > 0) ? q[0] : 0);
    comprobar("vacia", vacia, (q.size() == 0) ? 1 : 0);
    comprobar("llena", llena, (q.size() == DEPTH) ? 1 : 0);
    comprobar("descartes", descartes, m_desc);
  endtask

  task automatic esperar(input int n);
    repeat (n) tick();
  endtask

  task automatic reiniciar();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic pulsar(input int b);
    btn[b] = 1'b1; esperar(DEB + 2);
    btn[b] = 1'b0; esperar(DEB + 2);
  endtask

  task automatic sacar();
    consumir = 1'b1; tick(); consumir = 1'b0;
  endtask

  initial begin
    rst = 1'b1; btn = 5'd0; consumir = 1'b0;
    tick();
    comprobar("reset_sig", siguiente, 0);
    comprobar("reset_vacia", vacia, 1);
    comprobar("reset_llena", llena, 0);
    comprobar("reset_desc", descartes, 0);

    // 1: arriba held from cycle 0 -> visible exactly after edge DEB+1
    btn[0] = 1'b1; rst = 1'b0;
    esperar(DEB);
    comprobar("t1_vacia_e8", vacia, 1);
    tick();
    comprobar("t1_sig_e9", siguiente, 1);
    comprobar("t1_vacia_e9", vacia, 0);
    esperar(11);
    btn[0] = 1'b0; esperar(DEB + 2);
    sacar();
    comprobar("t1_unica", vacia, 1);

    // 2: bouncing derecha never accepted
    for (int i = 0; i < 10; i++) begin
      btn[3] = ~btn[3]; esperar(3);
    end
    btn[3] = 1'b0; esperar(DEB + 2);
    comprobar("t2_vacia", vacia, 1);
    comprobar("t2_desc", descartes, 0);

    // 3: simultaneous arriba and pausa -> only pause
    btn[0] = 1'b1; btn[4] = 1'b1;
    esperar(DEB + 1);
    comprobar("t3_sig", siguiente, 5);
    comprobar("t3_desc", descartes, 0);
    btn[0] = 1'b0; btn[4] = 1'b0; esperar(DEB + 2);
    sacar();
    comprobar("t3_unica", vacia, 1);

    // 4: overflow by one
    reiniciar();
    for (int b = 0; b < 4; b++) pulsar(b);
    comprobar("t4_llena", llena, 1);
    pulsar(4);
    comprobar("t4_desc", descartes, 1);
    for (int i = 0; i < 4; i++) begin
      comprobar("t4_orden", siguiente, i + 1);
      sacar();
    end
    comprobar("t4_vacia", vacia, 1);
    comprobar("t4_sig0", siguiente, 0);

    // 5: push and pop together while full
    reiniciar();
    for (int b = 0; b < 4; b++) pulsar(b);
    btn[4] = 1'b1;
    esperar(DEB);
    consumir = 1'b1; tick(); consumir = 1'b0;
    comprobar("t5_llena", llena, 1);
    comprobar("t5_desc", descartes, 0);
    comprobar("t5_cabeza", siguiente, 2);
    repeat (3) sacar();
    comprobar("t5_nuevo", siguiente, 5);
    btn[4] = 1'b0; esperar(DEB + 2);
    sacar();

    // 6: reset mid-operation with izquierda half-debounced and held
    reiniciar();
    pulsar(0); pulsar(1);
    btn[2] = 1'b1; esperar(4);
    rst = 1'b1; tick();
    comprobar("t6_vacia", vacia, 1);
    comprobar("t6_sig", siguiente, 0);
    comprobar("t6_desc", descartes, 0);
    rst = 1'b0;
    esperar(DEB);
    comprobar("t6_aun_vacia", vacia, 1);
    tick();
    comprobar("t6_requeue", siguiente, 3);
    btn[2] = 1'b0; esperar(DEB + 2);
    sacar();

    // 7: repeated izquierda presses
    reiniciar();
    repeat (3) pulsar(2);
    sacar();
`ifdef COLA_DESCARTE_REPETIDO_EN
    comprobar("t7_repetido", vacia, 1);
`else
    comprobar("t7_repetido", vacia, 0);
`endif
    repeat (3) sacar();

    // Random traffic with occasional resets
    reiniciar();
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 11) == 0) btn[b] = ~btn[b];
      consumir = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 999) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_comp, n_fail);
    $finish;
  end

endmodule
